// File: rtl/uart_loopback_tester.sv
// ---------------------------------------------------------------------------
// uart_loopback_tester
//
// Sends a run of NUM_BYTES pattern bytes to a UART transmitter and collects
// whatever the receiver hands back into a local FIFO. When the receive phase
// ends (all bytes seen, or the line has gone quiet for RX_TIMEOUT cycles),
// it regenerates the same pattern and compares it against the buffered bytes.
// A missing byte counts as one error.
//
// Parameters
//   NUM_BYTES   bytes per run (1..65535)
//   FIFO_DEPTH  receive buffer depth, power of two, >= NUM_BYTES
//   SEED        start value for LFSR and constant patterns
//   BUSY_LAT    cycles after tx_en before tx_busy is trusted
//   RX_TIMEOUT  quiet cycles before the receive phase is abandoned
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start, mode[1:0]     run request pulse and pattern select
//                        (0 count up, 1 LFSR, 2 constant SEED, 3 55/AA)
//   tx_en, tx_data[7:0]  send strobe and byte to the transmitter
//   tx_busy              transmitter busy
//   rx_done, rx_data     received-byte strobe and byte
//   busy, done, pass     run status
//   err_count, rx_count  mismatched/missing bytes, bytes received
//   overflow, timeout    sticky receive-side fault flags
// ---------------------------------------------------------------------------
module uart_loopback_tester #(
  parameter int unsigned NUM_BYTES  = 256,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter logic [7:0]  SEED       = 8'hA5,
  parameter int unsigned BUSY_LAT   = 2,
  parameter int unsigned RX_TIMEOUT = 200000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] rx_count,
  output logic        overflow,
  output logic        timeout
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = (BUSY_LAT > 1) ? $clog2(BUSY_LAT) : 1;
  localparam int unsigned TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  localparam logic [15:0]   NB       = 16'(NUM_BYTES);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAT_LAST = LW'((BUSY_LAT > 1) ? BUSY_LAT - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((RX_TIMEOUT > 1) ? RX_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, GEN, SEND, WAIT_LAT, WAIT_TX, RX_WAIT, DRAIN, CHECK, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [7:0]    gen;
  logic [15:0]   tx_count;
  logic [15:0]   cmp_count;
  logic [LW-1:0] lat_cnt;
  logic [TW-1:0] idle_cnt;

  logic [7:0]    mem [0:(1 << AW) - 1];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    rd_data;
  logic          rd_valid;

  logic          start_ok, rx_active, fifo_full, fifo_empty;
  logic          rx_wr, rd_en, to_hit, check_end;
  logic [15:0]   missing;
  logic [16:0]   err_sum;
  logic [15:0]   err_final;

  // First byte of each pattern; the LFSR and constant modes both start at SEED.
  function automatic logic [7:0] first_byte(input logic [1:0] m);
    case (m)
      2'd0:    first_byte = 8'h00;
      2'd3:    first_byte = 8'h55;
      default: first_byte = SEED;
    endcase
  endfunction

  // The LFSR uses taps 7,5,4,3 with an XNOR feedback, so the lock-up state is
  // 8'hFF rather than zero; this gives A5,4B,96,2D from the default seed.
  function automatic logic [7:0] next_byte(input logic [1:0] m, input logic [7:0] cur);
    case (m)
      2'd0:    next_byte = cur + 8'd1;
      2'd1:    next_byte = {cur[6:0], ~(cur[7] ^ cur[5] ^ cur[4] ^ cur[3])};
      2'd2:    next_byte = SEED;
      default: next_byte = ~cur;
    endcase
  endfunction

  assign start_ok   = start && (state == IDLE || state == DONE);
  assign rx_active  = (state != IDLE) && (state != DONE);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == DEPTH);
  assign rx_wr      = rx_done && rx_active && !fifo_full;
  assign rd_en      = (state == CHECK) && !fifo_empty;
  assign to_hit     = (state == RX_WAIT) && !rx_done && (idle_cnt == TO_LAST) && (rx_count < NB);
  assign check_end  = (state == CHECK) && fifo_empty && !rd_valid;

  // Bytes never compared count as errors once the buffer has been drained.
  assign missing    = NB - cmp_count;
  assign err_sum    = {1'b0, err_count} + {1'b0, missing};
  assign err_final  = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  assign tx_en = (state == SEND);
  assign busy  = rx_active;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = GEN;
      GEN:        state_nxt = SEND;
      SEND:       state_nxt = WAIT_LAT;
      WAIT_LAT:   if (lat_cnt == LAT_LAST) state_nxt = WAIT_TX;
      WAIT_TX:    if (!tx_busy) state_nxt = (tx_count < NB) ? GEN : RX_WAIT;
      RX_WAIT:    if (rx_count >= NB || to_hit) state_nxt = DRAIN;
      DRAIN:      state_nxt = CHECK;
      CHECK:      if (check_end) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Run datapath: pattern generator, counters, comparison and result flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q    <= 2'd0;
      gen       <= 8'h00;
      tx_data   <= 8'h00;
      tx_count  <= 16'd0;
      cmp_count <= 16'd0;
      lat_cnt   <= '0;
      idle_cnt  <= '0;
      err_count <= 16'd0;
      rx_count  <= 16'd0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
    end else if (start_ok) begin
      mode_q    <= mode;
      gen       <= first_byte(mode);
      tx_count  <= 16'd0;
      cmp_count <= 16'd0;
      lat_cnt   <= '0;
      idle_cnt  <= '0;
      err_count <= 16'd0;
      rx_count  <= 16'd0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        GEN: begin
          tx_data  <= gen;
          gen      <= next_byte(mode_q, gen);
          tx_count <= tx_count + 16'd1;
        end
        SEND:     lat_cnt <= '0;
        WAIT_LAT: lat_cnt <= lat_cnt + 1'b1;
        WAIT_TX:  idle_cnt <= '0;
        RX_WAIT: begin
          if (rx_done) idle_cnt <= '0;
          else         idle_cnt <= idle_cnt + 1'b1;
          if (to_hit)  timeout <= 1'b1;
        end
        DRAIN: begin
          gen       <= first_byte(mode_q);
          cmp_count <= 16'd0;
        end
        CHECK: begin
          // Anything read past NUM_BYTES is drained but not compared.
          if (rd_valid && cmp_count < NB) begin
            if (rd_data != gen && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            gen       <= next_byte(mode_q, gen);
            cmp_count <= cmp_count + 16'd1;
          end
          if (check_end) begin
            err_count <= err_final;
            done      <= 1'b1;
            pass      <= (err_final == 16'd0) && !overflow && !timeout && (rx_count == NB);
          end
        end
        default: ;
      endcase

      if (rx_done && rx_active) begin
        if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
        if (fifo_full)            overflow <= 1'b1;
      end
      if (rx_wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_en;
    end
  end

  // Receive buffer storage; read data appears the cycle after rd_en.
  always_ff @(posedge sys_clk) begin
    if (rx_wr) mem[wr_ptr[AW-1:0]] <= rx_data;
    if (rd_en) rd_data <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: tb/tb_uart_loopback_tester.sv
// ---------------------------------------------------------------------------
// tb_uart_loopback_tester
//
// Directed bench for uart_loopback_tester with NUM_BYTES=4, FIFO_DEPTH=4,
// RX_TIMEOUT=100. A task stands in for the UART: it answers each tx_en with
// tx_busy and loops the byte back on rx_done, optionally corrupting it,
// withholding it, or injecting an extra received byte.
// ---------------------------------------------------------------------------
module tb_uart_loopback_tester;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] rx_count;
  logic        overflow;
  logic        timeout;

  int          checks;
  int          errors;
  logic [7:0]  captured [4];

  uart_loopback_tester #(
    .NUM_BYTES  (4),
    .FIFO_DEPTH (4),
    .SEED       (8'hA5),
    .BUSY_LAT   (2),
    .RX_TIMEOUT (100)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .mode      (mode),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .rx_count  (rx_count),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  // 100 MHz free-running clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // All outputs at their reset values.
  task automatic check_idle(input string tag);
    check_output({tag, "_tx_en"},     tx_en,     16'd0);
    check_output({tag, "_tx_data"},   tx_data,   16'd0);
    check_output({tag, "_busy"},      busy,      16'd0);
    check_output({tag, "_done"},      done,      16'd0);
    check_output({tag, "_pass"},      pass,      16'd0);
    check_output({tag, "_err_count"}, err_count, 16'd0);
    check_output({tag, "_rx_count"},  rx_count,  16'd0);
    check_output({tag, "_overflow"},  overflow,  16'd0);
    check_output({tag, "_timeout"},   timeout,   16'd0);
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    check_output({tag, "_byte0"}, {8'h00, captured[0]}, {8'h00, e0});
    check_output({tag, "_byte1"}, {8'h00, captured[1]}, {8'h00, e1});
    check_output({tag, "_byte2"}, {8'h00, captured[2]}, {8'h00, e2});
    check_output({tag, "_byte3"}, {8'h00, captured[3]}, {8'h00, e3});
  endtask

  task automatic check_result(input string tag, input logic exp_pass, input logic [15:0] exp_err,
                              input logic [15:0] exp_rx, input logic exp_ovf, input logic exp_to);
    check_output({tag, "_busy"},      busy,      16'd0);
    check_output({tag, "_pass"},      pass,      {15'd0, exp_pass});
    check_output({tag, "_err_count"}, err_count, exp_err);
    check_output({tag, "_rx_count"},  rx_count,  exp_rx);
    check_output({tag, "_overflow"},  overflow,  {15'd0, exp_ovf});
    check_output({tag, "_timeout"},   timeout,   {15'd0, exp_to});
  endtask

  // Start pulse lasting exactly one rising edge; the DUT is then in GEN.
  task automatic apply_stimulus(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // UART stand-in for one byte: wait for tx_en, hold tx_busy, then loop back.
  task automatic serve_byte(input int idx, input bit deliver, input bit corrupt, input bit extra);
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check_output($sformatf("tx_en_seen%0d", idx), {15'd0, tx_en}, 16'd1);
    captured[idx] = tx_data;
    tx_busy = 1'b1;
    @(negedge sys_clk);
    check_output($sformatf("tx_en_single%0d", idx), {15'd0, tx_en}, 16'd0);
    repeat (3) @(negedge sys_clk);
    if (extra) begin
      rx_data = 8'hA5;
      rx_done = 1'b1;
      @(negedge sys_clk);
      rx_done = 1'b0;
    end
    tx_busy = 1'b0;
    if (deliver) begin
      rx_data = corrupt ? 8'h00 : captured[idx];
      rx_done = 1'b1;
    end
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(negedge sys_clk);
      n++;
    end
    check_output({tag, "_done"}, {15'd0, done}, 16'd1);
  endtask

  initial begin
    int pulses;
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    tx_busy   = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;

    $display("[TB] reset");
    repeat (3) @(negedge sys_clk);
    check_idle("rst");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    $display("[TB] mode 0 loopback");
    apply_stimulus(2'd0);
    check_output("m0_busy_run", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 4; i++) serve_byte(i, 1'b1, 1'b0, 1'b0);
    wait_done("m0");
    check_bytes("m0", 8'h00, 8'h01, 8'h02, 8'h03);
    check_result("m0", 1'b1, 16'd0, 16'd4, 1'b0, 1'b0);
    rx_data = 8'h11;
    rx_done = 1'b1;
    @(negedge sys_clk);
    rx_done = 1'b0;
    @(negedge sys_clk);
    check_output("done_rx_ignored", rx_count, 16'd4);
    check_output("done_hold", {15'd0, done}, 16'd1);

    $display("[TB] mode 1 LFSR");
    apply_stimulus(2'd1);
    for (int i = 0; i < 4; i++) serve_byte(i, 1'b1, 1'b0, 1'b0);
    wait_done("m1");
    check_bytes("m1", 8'hA5, 8'h4B, 8'h96, 8'h2D);
    check_result("m1", 1'b1, 16'd0, 16'd4, 1'b0, 1'b0);

    $display("[TB] mode 3 with corrupted second byte");
    apply_stimulus(2'd3);
    for (int i = 0; i < 4; i++) serve_byte(i, 1'b1, (i == 1), 1'b0);
    wait_done("m3");
    check_bytes("m3", 8'h55, 8'hAA, 8'h55, 8'hAA);
    check_result("m3", 1'b0, 16'd1, 16'd4, 1'b0, 1'b0);

    $display("[TB] receive timeout with one byte missing");
    apply_stimulus(2'd0);
    for (int i = 0; i < 4; i++) serve_byte(i, (i != 3), 1'b0, 1'b0);
    wait_done("to");
    check_result("to", 1'b0, 16'd1, 16'd3, 1'b0, 1'b1);

    $display("[TB] overflow from an extra received byte");
    apply_stimulus(2'd2);
    for (int i = 0; i < 4; i++) serve_byte(i, 1'b1, 1'b0, (i == 3));
    wait_done("ovf");
    check_bytes("ovf", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    check_result("ovf", 1'b0, 16'd0, 16'd5, 1'b1, 1'b0);

    $display("[TB] reset during WAIT_TX of byte 2");
    apply_stimulus(2'd0);
    serve_byte(0, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    while (tx_en !== 1'b1 && pulses < 100) begin
      @(negedge sys_clk);
      pulses++;
    end
    check_output("rst_mid_tx_en_seen", {15'd0, tx_en}, 16'd1);
    tx_busy = 1'b1;
    repeat (4) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    tx_busy = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (tx_en === 1'b1) pulses++;
    end
    check_output("rst_no_tx_en", pulses[15:0], 16'd0);
    check_output("rst_stay_idle", {15'd0, busy}, 16'd0);
    apply_stimulus(2'd0);
    for (int i = 0; i < 4; i++) serve_byte(i, 1'b1, 1'b0, 1'b0);
    wait_done("rerun");
    check_bytes("rerun", 8'h00, 8'h01, 8'h02, 8'h03);
    check_result("rerun", 1'b1, 16'd0, 16'd4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_loopback_tester.md
UART_LOOPBACK_TESTER -- requirements
Module: uart_loopback_tester

Interface
REQ-001 Parameter NUM_BYTES, default 256, number of bytes per test run (1..65535).
REQ-002 Parameter FIFO_DEPTH, default 256, receive buffer depth (power of two, >= NUM_BYTES).
REQ-003 Parameter SEED, default 8'hA5, start value for LFSR and constant modes.
REQ-004 Parameter BUSY_LAT, default 2, cycles from tx_en pulse until tx_busy is valid.
REQ-005 Parameter RX_TIMEOUT, default 200000, idle cycles without rx_done before the receive phase is abandoned.
REQ-006 sys_clk  in  1  clock; sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  single-cycle pulse; begins a run.
REQ-008 mode  in  2  pattern: 0 increment from 0, 1 LFSR, 2 constant SEED, 3 alternating 8'h55/8'hAA.
REQ-009 tx_en  out  1  single-cycle send strobe to UART transmitter; tx_data  out  8  byte to send.
REQ-010 tx_busy  in  1  transmitter busy.
REQ-011 rx_done  in  1  single-cycle byte-received strobe; rx_data  in  8  received byte.
REQ-012 busy  out  1  run in progress; done  out  1  run complete; pass  out  1  run passed.
REQ-013 err_count  out  16  mismatched or missing bytes; rx_count  out  16  bytes received this run.
REQ-014 overflow  out  1  byte dropped on full buffer; timeout  out  1  receive phase abandoned.

Function
REQ-015 States: IDLE, GEN, SEND, WAIT_LAT, WAIT_TX, RX_WAIT, DRAIN, CHECK, DONE.
REQ-016 start accepted only in IDLE or DONE; ignored otherwise; on accept: mode latched, counters, flags, FIFO and generator cleared, next state GEN.
REQ-017 GEN: tx_data loaded with current pattern byte, tx_count incremented -> SEND.
REQ-018 SEND: tx_en high exactly one cycle -> WAIT_LAT; tx_data stable from GEN until the next GEN.
REQ-019 WAIT_LAT: BUSY_LAT cycles elapse regardless of tx_busy -> WAIT_TX.
REQ-020 WAIT_TX: remain while tx_busy=1; when 0, go GEN if tx_count < NUM_BYTES, else RX_WAIT.
REQ-021 LFSR: 8-bit Fibonacci x^8+x^6+x^5+x^4+1, shift left, feedback bit into LSB, first byte SEED; generator advances once per GEN.
REQ-022 Mode 3 sequence starts 8'h55; mode 0 wraps 8'hFF -> 8'h00.
REQ-023 Receive path active in every state except IDLE and DONE: each rx_done writes rx_data to FIFO and increments rx_count (saturating at 16'hFFFF).
REQ-024 rx_done while FIFO full: byte dropped, overflow set sticky, rx_count still incremented.
REQ-025 rx_done in IDLE/DONE ignored.
REQ-026 RX_WAIT: -> DRAIN when rx_count >= NUM_BYTES, or when RX_TIMEOUT consecutive cycles pass with no rx_done (timeout set); idle counter restarts on every rx_done.
REQ-027 DRAIN: generator rewound to run-start value; FIFO read one entry per cycle, read data valid one cycle after read enable.
REQ-028 CHECK: each read byte compared to regenerated byte; mismatch increments err_count (saturating).
REQ-029 After FIFO empty, each of the NUM_BYTES minus (bytes compared) missing bytes adds one to err_count; bytes beyond NUM_BYTES in the FIFO are discarded uncompared.
REQ-030 -> DONE after comparison; done=1, busy=0; pass = (err_count==0) & ~overflow & ~timeout & (rx_count==NUM_BYTES).
REQ-031 busy=1 in every state except IDLE and DONE; done, pass, err_count, rx_count hold in DONE until next accepted start.
REQ-032 Simultaneous rx_done and FIFO read in the same cycle: both performed, occupancy unchanged.

Reset
REQ-033 sys_rst_n low asynchronously forces IDLE; tx_en=0, tx_data=0, busy=0, done=0, pass=0, err_count=0, rx_count=0, overflow=0, timeout=0, FIFO empty.
REQ-034 Reset mid-run abandons the run with no tx_en pulse emitted after reset assertion; start required to rerun.

Verification
REQ-035 NUM_BYTES=4, mode 0, tx looped to rx via UART model -> tx_data 00,01,02,03; done=1, pass=1, err_count=0, rx_count=4.
REQ-036 NUM_BYTES=4, mode 1 -> tx_data A5,4B,96,2D; pass=1.
REQ-037 NUM_BYTES=4, mode 3, bench corrupts second received byte to 8'h00 -> err_count=1, pass=0.
REQ-038 NUM_BYTES=4, RX_TIMEOUT=100, bench delivers only 3 bytes -> timeout=1, err_count=1, rx_count=3, pass=0.
REQ-039 FIFO_DEPTH=4, NUM_BYTES=4, bench injects 5 rx_done pulses -> overflow=1, rx_count=5, pass=0.
REQ-040 Assert sys_rst_n low during WAIT_TX of byte 2 -> all outputs at REQ-033 values; new start runs a clean 4-byte pass.
